// File: rtl/ro_puf_pair_counter_pkg.sv
// ---------------------------------------------------------------------------
// ro_puf_pkg
// Shared definitions for the RO-PUF pair counter, the RO bank and the bench.
//   state_e      : pair-counter FSM states (IDLE..DONE)
//   *_DEF        : default parameter values
//   chal_valid() : challenge legality check (distinct indices, both in range)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        COUNT   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int NUM_RO_DEF     = 8;
    localparam int SEL_W_DEF      = 3;
    localparam int CNT_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int WINDOW_DEF     = 1024;

    // A challenge must name two different ROs that both exist.
    function automatic logic chal_valid(input int a, input int b, input int num_ro);
        return (a != b) && (a < num_ro) && (b < num_ro);
    endfunction

endpackage

// File: rtl/ro_puf_pair_counter_if.sv
// ---------------------------------------------------------------------------
// ro_puf_pair_counter_if
// Request/response channel of the RO-PUF pair counter.
//   start, chal_a, chal_b  : request (requester -> counter)
//   busy                   : counter not idle
//   resp_valid/resp_ready  : response handshake
//   resp, err              : response bit and invalid-challenge flag
// Modports: master = requester, slave = pair counter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface ro_puf_pair_counter_if
    import ro_puf_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
);
    logic             start;
    logic [SEL_W-1:0] chal_a;
    logic [SEL_W-1:0] chal_b;
    logic             busy;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp;
    logic             err;

    modport master (
        output start, chal_a, chal_b, resp_ready,
        input  busy, resp_valid, resp, err
    );

    modport slave (
        input  start, chal_a, chal_b, resp_ready,
        output busy, resp_valid, resp, err
    );
endinterface

// File: rtl/ro_edge_counter.sv
// ---------------------------------------------------------------------------
// ro_edge_counter
// Counts rising edges of one asynchronous RO signal.
//   clk, rst : system clock, async active-high reset
//   ro_i     : raw RO output (asynchronous to clk)
//   clr_i    : hold count at zero
//   en_i     : count rising edges while high
//   cnt_o    : saturating edge count
// The edge-history flop always follows the synchronised value, so a counting
// window opened after a clear never sees a spurious first edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic             sync1_q;
    logic             sync2_q;
    logic             hist_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_s;

    assign rise_s = sync2_q & ~hist_q;
    assign cnt_o  = cnt_q;

    // Two-flop synchroniser, edge history and saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            if (clr_i) begin
                cnt_q <= {CNT_W{1'b0}};
            end else if (en_i && rise_s && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: rtl/ro_puf_pair_counter.sv
// ---------------------------------------------------------------------------
// ro_puf_pair_counter
// Enables a challenge-selected RO pair, counts both over a fixed window and
// answers 1 when RO a produced more edges than RO b.
//   clk, rst   : system clock, async active-high reset
//   bus        : request/response channel (slave modport)
//   ro_in_i    : raw RO outputs from the bank
//   ro_en_o    : per-RO enables to the bank
// Optional (macro RO_PUF_CNT_DBG_EN):
//   dbg_cnt_a_o, dbg_cnt_b_o : final counts latched in COMPARE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ro_puf_pair_counter
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO     = NUM_RO_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int WINDOW     = WINDOW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    ro_puf_pair_counter_if.slave bus,
    input  logic [NUM_RO-1:0]   ro_in_i,
    output logic [NUM_RO-1:0]   ro_en_o
`ifdef RO_PUF_CNT_DBG_EN
    ,
    output logic [CNT_W-1:0]    dbg_cnt_a_o,
    output logic [CNT_W-1:0]    dbg_cnt_b_o
`endif
);
    localparam int TMR_MAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   a_q, a_d, b_q, b_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
    logic               busy_q, busy_d;
    logic               rv_q, rv_d;
    logic               resp_q, resp_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_a_s, cnt_b_s;
    logic               clr_s, en_s;

    assign clr_s          = (state_q == SETTLE);
    assign en_s           = (state_q == COUNT);
    assign ro_en_o        = ro_en_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = rv_q;
    assign bus.resp       = resp_q;
    assign bus.err        = err_q;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk(clk), .rst(rst), .ro_i(ro_in_i[a_q]),
        .clr_i(clr_s), .en_i(en_s), .cnt_o(cnt_a_s)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk(clk), .rst(rst), .ro_i(ro_in_i[b_q]),
        .clr_i(clr_s), .en_i(en_s), .cnt_o(cnt_b_s)
    );

    // State and output registers; rst drops ro_en immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {SEL_W{1'b0}};
            b_q     <= {SEL_W{1'b0}};
            tmr_q   <= {TMR_W{1'b0}};
            ro_en_q <= {NUM_RO{1'b0}};
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tmr_q   <= tmr_d;
            ro_en_q <= ro_en_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tmr_d   = tmr_q;
        ro_en_d = ro_en_q;
        resp_d  = resp_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (chal_valid(int'(bus.chal_a), int'(bus.chal_b), NUM_RO)) begin
                        a_d                 = bus.chal_a;
                        b_d                 = bus.chal_b;
                        ro_en_d             = {NUM_RO{1'b0}};
                        ro_en_d[bus.chal_a] = 1'b1;
                        ro_en_d[bus.chal_b] = 1'b1;
                        tmr_d               = {TMR_W{1'b0}};
                        state_d             = SETTLE;
                    end else begin
                        err_d   = 1'b1;
                        resp_d  = 1'b0;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    tmr_d   = {TMR_W{1'b0}};
                    state_d = COUNT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            COUNT: begin
                if (tmr_q == TMR_W'(WINDOW - 1)) begin
                    tmr_d   = {TMR_W{1'b0}};
                    ro_en_d = {NUM_RO{1'b0}};
                    state_d = COMPARE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            COMPARE: begin
                resp_d  = (cnt_a_s > cnt_b_s);
                err_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                // rv_q gates acceptance so the first DONE cycle never accepts.
                if (rv_q && bus.resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                ro_en_d = {NUM_RO{1'b0}};
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        // resp_valid rises one cycle after DONE is entered and drops on acceptance.
        rv_d   = (state_q == DONE) && (state_d == DONE);
    end

`ifdef RO_PUF_CNT_DBG_EN
    logic [CNT_W-1:0] dbg_a_q, dbg_b_q;

    assign dbg_cnt_a_o = dbg_a_q;
    assign dbg_cnt_b_o = dbg_b_q;

    // Capture final counts alongside the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_a_q <= {CNT_W{1'b0}};
            dbg_b_q <= {CNT_W{1'b0}};
        end else if (state_q == COMPARE) begin
            dbg_a_q <= cnt_a_s;
            dbg_b_q <= cnt_b_s;
        end
    end
`endif
endmodule
